// File: rtl/my_fp_pkg.sv
// Shared FP32 field widths, special-value constants, divider FSM states and flag bit positions.
// Used by the divider and reusable by the FP32 multiplier.
package my_fp_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int SIG_W = MAN_W + 1;
    localparam int Q_W   = MAN_W + 2;
    localparam int REM_W = MAN_W + 3;

    localparam logic [31:0] FP_NAN     = 32'h7F800001;
    localparam logic [30:0] FP_INF_MAG = 31'h7F800000;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        NORM,
        DONE
    } state_t;

    localparam int FLAG_INVALID = 3;
    localparam int FLAG_DBZ     = 2;
    localparam int FLAG_OVF     = 1;
    localparam int FLAG_UNF     = 0;

    typedef struct packed {
        logic zero;
        logic inf;
        logic nan;
    } fp_class_t;

endpackage

// File: rtl/my_fp_div_if.sv
// Operand/result handshake bundle for my_fp_div; flags exist only with MY_FP_DIV_FLAGS_EN.
interface my_fp_div_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
`ifdef MY_FP_DIV_FLAGS_EN
    logic [3:0]  flags;
`endif

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, y
`ifdef MY_FP_DIV_FLAGS_EN
        , output flags
`endif
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, y
`ifdef MY_FP_DIV_FLAGS_EN
        , input flags
`endif
    );

endinterface

// File: rtl/my_fp_classify.sv
// Combinational FP32 classifier: zero / inf / nan. Subnormal encodings are not special here.
module my_fp_classify
    import my_fp_pkg::*;
(
    input  logic [31:0] x,
    output fp_class_t   cls
);

    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;

    assign e        = x[30:23];
    assign m        = x[22:0];
    assign cls.zero = (e == '0) && (m == '0);
    assign cls.inf  = (&e) && (m == '0);
    assign cls.nan  = (&e) && (m != '0);

endmodule

// File: rtl/my_fp_div.sv
// Sequential FP32 divider, radix-2 restoring, one quotient bit per cycle, truncating.
// Status flags {invalid, div_by_zero, overflow, underflow} are built only with MY_FP_DIV_FLAGS_EN.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   DIV   | one restoring step per cycle, cnt 0..24
//   NORM  | normalize quotient, range check, load y
//   DONE  | out_valid high, y held until out_ready
module my_fp_div
    import my_fp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    my_fp_div_if.slave bus
);

    state_t             state, nxt;
    fp_class_t          ca, cb;
    logic               ys_r;
    logic [EXP_W-1:0]   ea_r, eb_r;
    logic [SIG_W-1:0]   dvsr_r;
    logic [REM_W-1:0]   rem_r, rem_sel;
    logic [REM_W:0]     diff;
    logic [Q_W-1:0]     q_r;
    logic [4:0]         cnt_r;
    logic [31:0]        y_r, spec_y, norm_y;
    logic               ys, is_nan, is_inf, is_zero, special, q_bit;
    logic signed [9:0]  e_norm;
    logic [MAN_W-1:0]   man;

    my_fp_classify u_cls_a (.x(bus.a), .cls(ca));
    my_fp_classify u_cls_b (.x(bus.b), .cls(cb));

    always_comb begin
        ys      = bus.a[31] ^ bus.b[31];
        is_nan  = ca.nan | cb.nan | (ca.inf & cb.inf) | (ca.zero & cb.zero);
        is_inf  = ca.inf | (cb.zero & ~ca.zero);
        is_zero = ca.zero | cb.inf;
        special = is_nan | is_inf | is_zero;
        if (is_nan)      spec_y = {ys, FP_NAN[30:0]};
        else if (is_inf) spec_y = {ys, FP_INF_MAG};
        else             spec_y = {ys, 31'h0};
    end

    // Restoring step: the borrow out of the 27-bit subtract decides the quotient bit.
    always_comb begin
        diff    = {1'b0, rem_r} - {3'b000, dvsr_r};
        q_bit   = ~diff[REM_W];
        rem_sel = q_bit ? diff[REM_W-1:0] : rem_r;
    end

    always_comb begin
        e_norm = $signed({2'b00, ea_r}) - $signed({2'b00, eb_r})
                 + (q_r[Q_W-1] ? $signed(10'(BIAS)) : $signed(10'(BIAS - 1)));
        man    = q_r[Q_W-1] ? q_r[MAN_W:1] : q_r[MAN_W-1:0];
        if (e_norm <= 10'sd0)        norm_y = {ys_r, 31'h0};
        else if (e_norm >= 10'sd255) norm_y = {ys_r, FP_INF_MAG};
        else                         norm_y = {ys_r, e_norm[7:0], man};
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (bus.in_valid) nxt = special ? DONE : DIV;
            DIV:  if (cnt_r == 5'd24) nxt = NORM;
            NORM: nxt = DONE;
            DONE: if (bus.out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ys_r   <= 1'b0;
            ea_r   <= '0;
            eb_r   <= '0;
            dvsr_r <= '0;
            rem_r  <= '0;
            q_r    <= '0;
            cnt_r  <= '0;
            y_r    <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    ys_r   <= ys;
                    ea_r   <= bus.a[30:23];
                    eb_r   <= bus.b[30:23];
                    dvsr_r <= {1'b1, bus.b[22:0]};
                    rem_r  <= {2'b00, 1'b1, bus.a[22:0]};
                    q_r    <= '0;
                    cnt_r  <= '0;
                    if (special) y_r <= spec_y;
                end
                DIV: begin
                    rem_r <= rem_sel << 1;
                    q_r   <= {q_r[Q_W-2:0], q_bit};
                    if (cnt_r != 5'd24) cnt_r <= cnt_r + 5'd1;
                end
                NORM: y_r <= norm_y;
                default: ;
            endcase
        end
    end

`ifdef MY_FP_DIV_FLAGS_EN
    logic [3:0] flags_r, spec_flags, norm_flags;

    always_comb begin
        spec_flags               = '0;
        spec_flags[FLAG_INVALID] = is_nan;
        spec_flags[FLAG_DBZ]     = ~is_nan & cb.zero & ~ca.zero & ~ca.inf;
        norm_flags               = '0;
        norm_flags[FLAG_UNF]     = (e_norm <= 10'sd0);
        norm_flags[FLAG_OVF]     = (e_norm >= 10'sd255);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                flags_r <= '0;
        else if (state == IDLE && bus.in_valid && special) flags_r <= spec_flags;
        else if (state == NORM)                    flags_r <= norm_flags;
    end

    assign bus.flags = flags_r;
`endif

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.y         = y_r;

endmodule

// File: tb/tb_my_fp_div.sv
// Scoreboard bench for my_fp_div: directed and random operands against an arithmetic reference model.
module tb_my_fp_div;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    my_fp_div_if bus();

    my_fp_div dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [3:0]  f;
        int          lat;
        time         t_acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   bp_hold = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference: classify by field values, then q = floor(2^24 * sigA / sigB) with plain integers.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] y, output logic [3:0] f, output int lat);
        logic        ys;
        logic [7:0]  ea, eb;
        logic [22:0] ma, mb, man;
        logic        az, ai, an, bz, bi, bn;
        logic [63:0] num, den, q;
        int          e;
        ys = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        ma = a[22:0];  mb = b[22:0];
        az = (ea == 0) && (ma == 0);    bz = (eb == 0) && (mb == 0);
        ai = (ea == 255) && (ma == 0);  bi = (eb == 255) && (mb == 0);
        an = (ea == 255) && (ma != 0);  bn = (eb == 255) && (mb != 0);
        f = 4'b0;
        lat = 1;
        if (an || bn || (ai && bi) || (az && bz)) begin
            y = {ys, 8'hFF, 23'h1};
            f[3] = 1'b1;
        end else if (ai || bz) begin
            y = {ys, 8'hFF, 23'h0};
            if (bz && !ai) f[2] = 1'b1;
        end else if (az || bi) begin
            y = {ys, 31'h0};
        end else begin
            lat = 27;
            num = {40'h0, 1'b1, ma} << 24;
            den = {40'h0, 1'b1, mb};
            q   = num / den;
            e   = int'(ea) - int'(eb) + 127;
            if (q < 64'h100_0000) begin
                e   = e - 1;
                man = q[22:0];
            end else begin
                man = q[23:1];
            end
            if (e <= 0) begin
                y = {ys, 31'h0};
                f[0] = 1'b1;
            end else if (e >= 255) begin
                y = {ys, 8'hFF, 23'h0};
                f[1] = 1'b1;
            end else begin
                y = {ys, 8'(e), man};
            end
        end
    endfunction

    // Presents operands at a negedge and holds them (in_valid high) until accepted.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        bit   ok;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) begin
            e.a = a;
            e.b = b;
            model(a, b, e.y, e.f, e.lat);
            e.t_acc = $time;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] m;
        int          r;
        r = int'($urandom_range(0, 11));
        if (r == 0)      e = 8'h00;
        else if (r == 1) e = 8'hFF;
        else             e = 8'($urandom_range(1, 254));
        m = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
        return {1'($urandom), e, m};
    endfunction

    // Monitor: pops the scoreboard whenever a result is presented, applies random backpressure.
    initial begin
        exp_t        e;
        logic [31:0] y_hold;
        int          hold;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("y(%h/%h)", e.a, e.b), bus.y, e.y);
`ifdef MY_FP_DIV_FLAGS_EN
                    check($sformatf("flags(%h/%h)", e.a, e.b), 32'(bus.flags), 32'(e.f));
`endif
                    check($sformatf("latency(%h/%h)", e.a, e.b),
                          32'(($time - e.t_acc + 5) / 10), 32'(e.lat));
                    check("in_ready_while_done", 32'(bus.in_ready), 32'd0);
                end
                hold = (bp_hold > 0) ? bp_hold : int'($urandom_range(0, 2));
                bp_hold = 0;
                y_hold = bus.y;
                for (int i = 0; i < hold; i++) begin
                    @(negedge clk);
                    check("bp_y_stable", bus.y, y_hold);
                    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
                    check("bp_in_ready", 32'(bus.in_ready), 32'd0);
                end
                bus.out_ready = 1'b1;
                @(negedge clk);
                bus.out_ready = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_y", bus.y, 32'h0);
`ifdef MY_FP_DIV_FLAGS_EN
        check("rst_flags", 32'(bus.flags), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        issue(32'h40C00000, 32'h40000000, 1);
        issue(32'hC0C00000, 32'h40000000, 1);
        issue(32'h3F800000, 32'h40400000, 1);
        issue(32'h3F800000, 32'h00000000, 1);
        issue(32'h00000000, 32'h00000000, 1);
        issue(32'h7F800000, 32'h7F800000, 1);
        issue(32'h00800000, 32'h40000000, 1);
        issue(32'h7F000000, 32'h3F000000, 1);
        issue(32'h7FC00000, 32'h3F800000, 1);
        issue(32'h3F800000, 32'h7F800000, 1);
        wait_drain();

        // Backpressure: second operands are held high while the first result is stalled.
        bp_hold = 5;
        issue(32'h40C00000, 32'h40000000, 1);
        issue(32'h3F800000, 32'h40400000, 1);
        wait_drain();

        // Reset mid-DIV: no result may appear afterwards.
        issue(32'h40C00000, 32'h40000000, 0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_y", bus.y, 32'h0);
`ifdef MY_FP_DIV_FLAGS_EN
        check("midrst_flags", 32'(bus.flags), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(32'h40C00000, 32'h40000000, 1);
        wait_drain();

        for (int i = 0; i < 150; i++) begin
            issue(rand_fp(), rand_fp(), 1);
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
